// File: rtl/regbus_arbiter_if.sv
// Bundle for the two requester ports, the register-file select bus and the error pulse.
// The arbiter connects through the slave modport; requesters and the register file use master.
interface regbus_arbiter_if #(
   parameter int AW  = 16,
   parameter int DW  = 32,
   parameter int PAW = 7
);
   logic          m0_read;
   logic          m0_write;
   logic [AW-1:0] m0_addr;
   logic [DW-1:0] m0_wr_data;
   logic [1:0]    m0_wr_width;
   logic          m0_ready;
   logic [DW-1:0] m0_rd_data;

   logic          m1_read;
   logic          m1_write;
   logic [AW-1:0] m1_addr;
   logic [DW-1:0] m1_wr_data;
   logic [1:0]    m1_wr_width;
   logic          m1_ready;
   logic [DW-1:0] m1_rd_data;

   logic           psel;
   logic           pwrite;
   logic [PAW-1:0] paddr;
   logic [DW-1:0]  pwdata;
   logic [1:0]     psize;
   logic [DW-1:0]  prdata;
   logic           addr_err;

   modport slave (
      input  m0_read, m0_write, m0_addr, m0_wr_data, m0_wr_width,
      output m0_ready, m0_rd_data,
      input  m1_read, m1_write, m1_addr, m1_wr_data, m1_wr_width,
      output m1_ready, m1_rd_data,
      output psel, pwrite, paddr, pwdata, psize,
      input  prdata,
      output addr_err
   );

   modport master (
      output m0_read, m0_write, m0_addr, m0_wr_data, m0_wr_width,
      input  m0_ready, m0_rd_data,
      output m1_read, m1_write, m1_addr, m1_wr_data, m1_wr_width,
      input  m1_ready, m1_rd_data,
      input  psel, pwrite, paddr, pwdata, psize,
      output prdata,
      input  addr_err
   );
endinterface

// File: rtl/regbus_arbiter.sv
// Round-robin arbiter serialising two requesters onto the register-file select bus,
// with a fixed number of wait-state select cycles and out-of-range address trapping.
//
// state  | meaning
// IDLE   | no transaction; arbitrate and capture the winning command
// ACCESS | first select cycle on the register-file bus
// WAITS  | extra select cycles, bus held stable, counter runs down to 0
// DONE   | select dropped; ready (and addr_err on a trapped access) to the served master
module regbus_arbiter #(
   parameter int            AW       = 16,
   parameter int            DW       = 32,
   parameter int            PAW      = 7,
   parameter int            WAIT     = 0,
   parameter logic [DW-1:0] ERR_DATA = DW'(32'hDEAD_BEEF)
) (
   input logic            clk,
   input logic            rst_n,
   regbus_arbiter_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAITS, S_DONE} state_t;

   localparam logic [3:0] WAIT_CNT = 4'(WAIT);

   state_t         state, state_nxt;
   logic           last_grant;
   logic [3:0]     wait_cnt;
   logic [PAW-1:0] cmd_addr;
   logic [DW-1:0]  cmd_wdata;
   logic [1:0]     cmd_width;
   logic           cmd_wr;
   logic           cmd_id;
   logic           cmd_err;
   logic [DW-1:0]  rd_data0, rd_data1;

   logic          req0, req1;
   logic          sel1;
   logic [AW-1:0] gnt_addr;
   logic          gnt_wr;
   logic          gnt_err;
   logic          grant;
   logic          sel_on;
   logic          last_beat;
   logic          ready0, ready1;
   logic          err_pulse;

   assign req0 = bus.m0_read | bus.m0_write;
   assign req1 = bus.m1_read | bus.m1_write;
   // On contention the master that was not granted last time wins.
   assign sel1     = (req0 & req1) ? ~last_grant : req1;
   assign gnt_addr = sel1 ? bus.m1_addr  : bus.m0_addr;
   assign gnt_wr   = sel1 ? bus.m1_write : bus.m0_write;
   assign gnt_err  = |gnt_addr[AW-1:PAW];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      sel_on    = 1'b0;
      last_beat = 1'b0;
      ready0    = 1'b0;
      ready1    = 1'b0;
      err_pulse = 1'b0;
      case (state)
         S_IDLE: begin
            if (req0 | req1) begin
               grant     = 1'b1;
               state_nxt = gnt_err ? S_DONE : S_ACCESS;
            end
         end
         S_ACCESS: begin
            sel_on = 1'b1;
            if (WAIT == 0) begin
               last_beat = 1'b1;
               state_nxt = S_DONE;
            end else begin
               state_nxt = S_WAITS;
            end
         end
         S_WAITS: begin
            sel_on = 1'b1;
            if (wait_cnt == 4'd0) begin
               last_beat = 1'b1;
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            ready0    = ~cmd_id;
            ready1    = cmd_id;
            err_pulse = cmd_err;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= 1'b1;
         wait_cnt   <= 4'd0;
         cmd_addr   <= '0;
         cmd_wdata  <= '0;
         cmd_width  <= 2'd0;
         cmd_wr     <= 1'b0;
         cmd_id     <= 1'b0;
         cmd_err    <= 1'b0;
         rd_data0   <= '0;
         rd_data1   <= '0;
      end else begin
         if (grant) begin
            last_grant <= sel1;
            cmd_id     <= sel1;
            cmd_wr     <= gnt_wr;
            cmd_err    <= gnt_err;
            cmd_addr   <= gnt_addr[PAW-1:0];
            cmd_wdata  <= sel1 ? bus.m1_wr_data  : bus.m0_wr_data;
            cmd_width  <= sel1 ? bus.m1_wr_width : bus.m0_wr_width;
            if (gnt_err && !gnt_wr) begin
               if (sel1) rd_data1 <= ERR_DATA;
               else      rd_data0 <= ERR_DATA;
            end
         end
         if (state == S_ACCESS)
            wait_cnt <= WAIT_CNT - 4'd1;
         else if (state == S_WAITS && wait_cnt != 4'd0)
            wait_cnt <= wait_cnt - 4'd1;
         // prdata is combinational from paddr, so the last select cycle sees the final value.
         if (last_beat && !cmd_wr) begin
            if (cmd_id) rd_data1 <= bus.prdata;
            else        rd_data0 <= bus.prdata;
         end
      end
   end

   assign bus.psel       = sel_on;
   assign bus.pwrite     = sel_on & cmd_wr;
   assign bus.paddr      = cmd_addr;
   assign bus.pwdata     = cmd_wdata;
   assign bus.psize      = cmd_width;
   assign bus.m0_ready   = ready0;
   assign bus.m1_ready   = ready1;
   assign bus.m0_rd_data = rd_data0;
   assign bus.m1_rd_data = rd_data1;
   assign bus.addr_err   = err_pulse;

endmodule

// File: doc/regbus_arbiter.md
Name: regbus_arbiter

Overview:
- Two-master arbiter and sequencer in front of the configuration register file.
- Master 0 is the JTAG memory port; master 1 is a second on-chip requester, e.g. a debug or boot sequencer.
- Serialises both masters' read/write requests onto the single register-file select bus, with round-robin fairness and a programmable wait-state count.
- Returns read data and a one-cycle ready pulse to the master that was served.

Parameters:
- AW, 16: master address width.
- DW, 32: data width.
- PAW, 7: register-file address width. Master address bits above PAW-1 must be zero.
- WAIT, 0: extra select cycles per access, 0..15.
- ERR_DATA, 32'hDEAD_BEEF: read data returned on an out-of-range access.

Ports:
- clk  in  1  single clock (same clock as the JTAG TCK domain).
- rst_n  in  1  reset, asynchronous and active-low.
- m0_read  in  1  master 0 read request (level, held until m0_ready).
- m0_write  in  1  master 0 write request (level).
- m0_addr  in  AW  master 0 address.
- m0_wr_data  in  DW  master 0 write data.
- m0_wr_width  in  2  master 0 write size.
- m0_ready  out  1  one-cycle completion pulse to master 0.
- m0_rd_data  out  DW  read data to master 0.
- m1_read, m1_write, m1_addr, m1_wr_data, m1_wr_width, m1_ready, m1_rd_data: same as master 0, for master 1.
- psel  out  1  register-file select.
- pwrite  out  1  register-file write strobe qualifier.
- paddr  out  PAW  register-file address.
- pwdata  out  DW  register-file write data.
- psize  out  2  register-file write size.
- prdata  in  DW  register-file read data (combinational from paddr).
- addr_err  out  1  one-cycle pulse when an out-of-range access completes.

Behaviour:
- Reset values (asynchronous): all outputs 0, except m*_rd_data = 0. State = IDLE, last_grant = 1 (so master 0 wins first), wait counter = 0.
- Request decode per master: req = read | write. If both read and write are high, it is treated as a write.
- Arbitration, evaluated in IDLE only:
  - One requester: grant it.
  - Both requesting: grant the master that is not last_grant. last_grant updates on every grant.
  - The losing master's request stays pending and is served next.
- On grant, the command is captured into registers: addr[PAW-1:0], wr_data, wr_width, the write bit and the grant id. A master changing or dropping its inputs afterwards has no effect on the transaction in flight.
- FSM states: IDLE, ACCESS, WAITS, DONE.
  - IDLE: no req stays in IDLE. Grant with in-range address goes to ACCESS. Grant with out-of-range address (any of addr[AW-1:PAW] set) goes to DONE with the error flag set.
  - ACCESS: psel = 1, pwrite = captured write bit, paddr/pwdata/psize from the captured registers. Goes to DONE if WAIT == 0, else to WAITS with counter = WAIT-1.
  - WAITS: psel, pwrite and the bus held stable. Counter decrements each cycle; at 0, goes to DONE.
  - DONE: psel = 0. The granted master's ready is 1 for exactly this cycle. Goes to IDLE.
- Write commit: exactly one write per transaction. pwrite is high only while psel is high; the register file samples on the final psel cycle.
- Read data: prdata is captured into the granted master's rd_data on the final psel cycle, so it is valid in DONE. It holds until that master's next read completes. The other master's rd_data is not disturbed.
- Error access: no psel is issued. rd_data = ERR_DATA for a read; a write is dropped. addr_err pulses in DONE together with ready.
- Latency: request seen in IDLE at cycle N; psel in cycles N+1..N+1+WAIT; ready at N+2+WAIT. Error access: ready at N+1.
- Back-to-back: IDLE is entered for at least one cycle between transactions. A master holding its request after ready is served again, subject to round-robin. Minimum transaction period is 3+WAIT cycles.
- Reset asserted mid-transaction: the transaction is aborted immediately, psel drops, no ready is issued, and no partial write is committed after reset.

Test Plan:
- Reset, then m0 read of addr 0x04 with prdata=0x12345678, WAIT=0 -> psel high for 1 cycle with paddr=0x04, pwrite=0; m0_ready pulses 2 cycles after the request; m0_rd_data=0x12345678.
- m0 and m1 write simultaneously (m0 addr 0x08 data 0xA5A5A5A5, m1 addr 0x0C data 0x5A5A5A5A) -> m0 served first, then m1. Two distinct psel windows with matching paddr/pwdata; m0_ready then m1_ready, 3 cycles apart.
- Both masters hold read requests continuously for 6 transactions -> grants alternate m0,m1,m0,m1,m0,m1 and no master is starved.
- WAIT=3, m1 read of 0x10 -> psel high for exactly 4 cycles with bus stable; m1_ready at request+5.
- m0 read of addr 0x0100 (out of range for PAW=7) -> no psel; m0_ready and addr_err pulse 1 cycle later; m0_rd_data=0xDEADBEEF. Repeat as a write -> no psel, addr_err pulses.
- Assert rst_n low during WAITS of an m0 write -> psel=0 immediately, no m0_ready; after release the FSM is in IDLE and a fresh read of the same address returns the prior register value.
